// File: rtl/sal_bk_ctrl.sv
// Per-bank DDR2 state machine: tracks IDLE/ACTIVE/PRECHARGING/REFRESHING,
// enforces tRCD/tRAS/tRTP/tWTP/tRP/tRFC with countdowns, and flags illegal commands.
module sal_bk_ctrl #(
  parameter int TIMER_W = 8,
  parameter int ROW_W   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TIMER_W-1:0] t_rcd,
  input  logic [TIMER_W-1:0] t_rp,
  input  logic [TIMER_W-1:0] t_ras,
  input  logic [TIMER_W-1:0] t_rfc,
  input  logic [TIMER_W-1:0] t_rtp,
  input  logic [TIMER_W-1:0] t_wtp,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_type,
  input  logic [ROW_W-1:0]   cmd_row,
  output logic               act_ok,
  output logic               rdwr_ok,
  output logic               pre_ok,
  output logic               ref_ok,
  output logic               row_open,
  output logic [ROW_W-1:0]   open_row,
  output logic               cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_PRECH  = 2'd2,
    S_REFR   = 2'd3
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  localparam logic [TIMER_W-1:0] ZERO = TIMER_W'(0);
  localparam logic [TIMER_W-1:0] ONE  = TIMER_W'(1);

  // A timing of t cycles loads t-1 so the ok rises exactly t cycles after the command.
  function automatic logic [TIMER_W-1:0] load_val(input logic [TIMER_W-1:0] t);
    return (t == ZERO) ? ZERO : (t - ONE);
  endfunction

  function automatic logic [TIMER_W-1:0] dec_sat(input logic [TIMER_W-1:0] c);
    return (c == ZERO) ? ZERO : (c - ONE);
  endfunction

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] rcd_cnt_q, rcd_cnt_d;
  logic [TIMER_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [TIMER_W-1:0] rtp_cnt_q, rtp_cnt_d;
  logic [TIMER_W-1:0] wtp_cnt_q, wtp_cnt_d;
  logic [TIMER_W-1:0] rp_rfc_cnt_q, rp_rfc_cnt_d;
  logic [ROW_W-1:0]   open_row_q, open_row_d;
  logic               cmd_err_q, cmd_err_d;
  logic               cmd_legal_s;
  logic               accept_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rcd_cnt_q    <= ZERO;
      ras_cnt_q    <= ZERO;
      rtp_cnt_q    <= ZERO;
      wtp_cnt_q    <= ZERO;
      rp_rfc_cnt_q <= ZERO;
      open_row_q   <= {ROW_W{1'b0}};
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcd_cnt_q    <= rcd_cnt_d;
      ras_cnt_q    <= ras_cnt_d;
      rtp_cnt_q    <= rtp_cnt_d;
      wtp_cnt_q    <= wtp_cnt_d;
      rp_rfc_cnt_q <= rp_rfc_cnt_d;
      open_row_q   <= open_row_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_comb begin
    case (cmd_type)
      CMD_NOP:        cmd_legal_s = 1'b1;
      CMD_ACT:        cmd_legal_s = act_ok;
      CMD_RD, CMD_WR: cmd_legal_s = rdwr_ok;
      CMD_PRE:        cmd_legal_s = pre_ok;
      CMD_REF:        cmd_legal_s = ref_ok;
      default:        cmd_legal_s = 1'b0;
    endcase
    accept_s  = cmd_valid && cmd_legal_s && (cmd_type != CMD_NOP);
    cmd_err_d = cmd_valid && !cmd_legal_s;

    state_d      = state_q;
    rcd_cnt_d    = dec_sat(rcd_cnt_q);
    ras_cnt_d    = dec_sat(ras_cnt_q);
    rtp_cnt_d    = dec_sat(rtp_cnt_q);
    wtp_cnt_d    = dec_sat(wtp_cnt_q);
    rp_rfc_cnt_d = dec_sat(rp_rfc_cnt_q);
    open_row_d   = open_row_q;

    if (accept_s) begin
      case (cmd_type)
        CMD_ACT: begin
          state_d    = S_ACTIVE;
          rcd_cnt_d  = load_val(t_rcd);
          ras_cnt_d  = load_val(t_ras);
          rtp_cnt_d  = ZERO;
          wtp_cnt_d  = ZERO;
          open_row_d = cmd_row;
        end
        CMD_RD:  rtp_cnt_d = load_val(t_rtp);
        CMD_WR:  wtp_cnt_d = load_val(t_wtp);
        CMD_PRE: begin
          state_d      = S_PRECH;
          rp_rfc_cnt_d = load_val(t_rp);
        end
        CMD_REF: begin
          state_d      = S_REFR;
          rp_rfc_cnt_d = load_val(t_rfc);
        end
        default: state_d = state_q;
      endcase
    end else if (((state_q == S_PRECH) || (state_q == S_REFR)) && (rp_rfc_cnt_q == ZERO)) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Legality depends only on registered state, so it is valid early in the cycle.
  always_comb begin
    act_ok   = (state_q == S_IDLE) ||
               (((state_q == S_PRECH) || (state_q == S_REFR)) && (rp_rfc_cnt_q == ZERO));
    ref_ok   = act_ok;
    rdwr_ok  = (state_q == S_ACTIVE) && (rcd_cnt_q == ZERO);
    pre_ok   = (state_q == S_ACTIVE) && (ras_cnt_q == ZERO) &&
               (rtp_cnt_q == ZERO) && (wtp_cnt_q == ZERO);
    row_open = (state_q == S_ACTIVE);
    open_row = open_row_q;
    cmd_err  = cmd_err_q;
  end

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Bench for sal_bk_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a timestamp-based bank model.
module tb_sal_bk_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  t_rcd = 8'd4, t_rp = 8'd4, t_ras = 8'd12, t_rfc = 8'd42, t_rtp = 8'd2, t_wtp = 8'd10;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_type = 3'd0;
  logic [13:0] cmd_row = 14'd0;
  logic        act_ok, rdwr_ok, pre_ok, ref_ok, row_open, cmd_err;
  logic [13:0] open_row;

  int checks = 0;
  int errors = 0;
  int tcur = 0;

  sal_bk_ctrl #(.TIMER_W(8), .ROW_W(14)) dut (
    .clk(clk), .rst(rst),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc), .t_rtp(t_rtp), .t_wtp(t_wtp),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_row(cmd_row),
    .act_ok(act_ok), .rdwr_ok(rdwr_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
    .row_open(row_open), .open_row(open_row), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Model: bank mode plus absolute cycle numbers at which each restriction lifts.
  localparam int M_IDLE = 0, M_OPEN = 1, M_PRE = 2, M_REF = 3;
  int          now = 0;
  int          m_mode = M_IDLE;
  int          rcd_at = 0, ras_at = 0, rtp_at = 0, wtp_at = 0, busy_at = 0;
  logic [13:0] m_row = 14'd0;
  logic        m_err = 1'b0;

  function automatic int mx1(input int t);
    return (t < 1) ? 1 : t;
  endfunction

  function automatic bit m_act_ok();
    return (m_mode == M_IDLE) || (((m_mode == M_PRE) || (m_mode == M_REF)) && (now >= busy_at));
  endfunction

  function automatic bit m_rdwr_ok();
    return (m_mode == M_OPEN) && (now >= rcd_at);
  endfunction

  function automatic bit m_pre_ok();
    return (m_mode == M_OPEN) && (now >= ras_at) && (now >= rtp_at) && (now >= wtp_at);
  endfunction

  task automatic model_edge();
    bit ok;
    bit acc;
    if (rst) begin
      m_mode = M_IDLE;
      rcd_at = 0; ras_at = 0; rtp_at = 0; wtp_at = 0; busy_at = 0;
      m_row = 14'd0;
      m_err = 1'b0;
    end else begin
      case (cmd_type)
        3'd0:       ok = 1'b1;
        3'd1, 3'd5: ok = m_act_ok();
        3'd2, 3'd3: ok = m_rdwr_ok();
        3'd4:       ok = m_pre_ok();
        default:    ok = 1'b0;
      endcase
      m_err = cmd_valid && !ok;
      acc   = cmd_valid && ok && (cmd_type != 3'd0);
      if (acc) begin
        case (cmd_type)
          3'd1: begin
            m_mode = M_OPEN;
            rcd_at = now + mx1(int'(t_rcd));
            ras_at = now + mx1(int'(t_ras));
            rtp_at = 0;
            wtp_at = 0;
            m_row  = cmd_row;
          end
          3'd2: rtp_at = now + mx1(int'(t_rtp));
          3'd3: wtp_at = now + mx1(int'(t_wtp));
          3'd4: begin m_mode = M_PRE; busy_at = now + mx1(int'(t_rp)); end
          3'd5: begin m_mode = M_REF; busy_at = now + mx1(int'(t_rfc)); end
          default: ;
        endcase
      end else if (((m_mode == M_PRE) || (m_mode == M_REF)) && (now >= busy_at)) begin
        m_mode = M_IDLE;
      end
    end
    now++;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d (cycle %0d): got %0h expected %0h", name, tcur, now, act, exp);
    end
  endtask

  task automatic compare_all();
    check1("act_ok",   32'(act_ok),   32'(m_act_ok()));
    check1("ref_ok",   32'(ref_ok),   32'(m_act_ok()));
    check1("rdwr_ok",  32'(rdwr_ok),  32'(m_rdwr_ok()));
    check1("pre_ok",   32'(pre_ok),   32'(m_pre_ok()));
    check1("row_open", 32'(row_open), 32'(m_mode == M_OPEN));
    check1("open_row", 32'(open_row), 32'(m_row));
    check1("cmd_err",  32'(cmd_err),  32'(m_err));
  endtask

  task automatic step(input bit v, input logic [2:0] ty, input logic [13:0] row);
    cmd_valid = v;
    cmd_type  = ty;
    cmd_row   = row;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    tcur++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 3'd0, 14'd0);
    rst = 1'b0;
    tcur = 0;
  endtask

  task automatic run_to(input int t);
    while (tcur < t) step(1'b0, 3'd0, 14'd0);
  endtask

  initial begin
    int q[$];
    int r;

    // Reset state
    do_reset();
    check1("rst_act_ok",   32'(act_ok),   32'd1);
    check1("rst_ref_ok",   32'(ref_ok),   32'd1);
    check1("rst_rdwr_ok",  32'(rdwr_ok),  32'd0);
    check1("rst_pre_ok",   32'(pre_ok),   32'd0);
    check1("rst_row_open", 32'(row_open), 32'd0);
    check1("rst_cmd_err",  32'(cmd_err),  32'd0);

    // ACT row 0x1A5 at 0
    step(1'b1, 3'd1, 14'h1A5);
    check1("act_open_row", 32'(open_row), 32'h1A5);
    check1("act_row_open", 32'(row_open), 32'd1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step(1'b0, 3'd0, 14'd0);
      check1("act_rdwr_rise", 32'(rdwr_ok), 32'(tcur >= 4));
      check1("act_pre_rise",  32'(pre_ok),  32'(tcur >= 12));
    end

    // WR at 8 delays PRE to 18
    do_reset();
    step(1'b1, 3'd1, 14'h0033);
    run_to(8);
    step(1'b1, 3'd3, 14'd0);
    while (tcur < 20) begin
      check1("wr_pre_ok", 32'(pre_ok), 32'(tcur >= 18));
      step(1'b0, 3'd0, 14'd0);
    end

    // RD at 11 delays PRE to 13
    do_reset();
    step(1'b1, 3'd1, 14'h0044);
    run_to(11);
    step(1'b1, 3'd2, 14'd0);
    check1("rd_pre_12", 32'(pre_ok), 32'd0);
    step(1'b0, 3'd0, 14'd0);
    check1("rd_pre_13", 32'(pre_ok), 32'd1);

    // PRE at 20, ACT at 24 goes straight to ACTIVE
    do_reset();
    step(1'b1, 3'd1, 14'h0155);
    run_to(20);
    check1("pre_ok_20", 32'(pre_ok), 32'd1);
    step(1'b1, 3'd4, 14'd0);
    while (tcur < 24) begin
      check1("pre_act_ok", 32'(act_ok), 32'd0);
      step(1'b0, 3'd0, 14'd0);
    end
    check1("pre_act_ok_24", 32'(act_ok), 32'd1);
    check1("pre_keep_row", 32'(open_row), 32'h155);
    step(1'b1, 3'd1, 14'h0266);
    check1("react_row_open", 32'(row_open), 32'd1);
    check1("react_open_row", 32'(open_row), 32'h266);

    // REF at 0, illegal RD at 5, reserved code at 6
    do_reset();
    step(1'b1, 3'd5, 14'd0);
    run_to(5);
    step(1'b1, 3'd2, 14'd0);
    check1("ref_err_6", 32'(cmd_err), 32'd1);
    step(1'b1, 3'd7, 14'd0);
    check1("ref_err_7", 32'(cmd_err), 32'd1);
    check1("ref_row_open", 32'(row_open), 32'd0);
    step(1'b0, 3'd0, 14'd0);
    check1("ref_err_8", 32'(cmd_err), 32'd0);
    while (tcur < 43) begin
      check1("ref_act_ok", 32'(act_ok), 32'(tcur >= 42));
      step(1'b0, 3'd0, 14'd0);
    end

    // t_rcd = 0
    t_rcd = 8'd0;
    do_reset();
    step(1'b1, 3'd1, 14'h0001);
    check1("rcd0_rdwr_ok", 32'(rdwr_ok), 32'd1);
    t_rcd = 8'd4;

    // Reset in the middle of a refresh
    do_reset();
    step(1'b1, 3'd5, 14'd0);
    run_to(10);
    rst = 1'b1;
    step(1'b1, 3'd1, 14'h0777);
    rst = 1'b0;
    check1("midref_act_ok",   32'(act_ok),   32'd1);
    check1("midref_row_open", 32'(row_open), 32'd0);
    check1("midref_open_row", 32'(open_row), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        t_rcd = 8'($urandom_range(0, 6));
        t_rp  = 8'($urandom_range(0, 6));
        t_ras = 8'($urandom_range(0, 15));
        t_rfc = 8'($urandom_range(0, 20));
        t_rtp = 8'($urandom_range(0, 4));
        t_wtp = 8'($urandom_range(0, 12));
        rst = 1'b1;
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 14'($urandom));
        rst = 1'b0;
      end else if (r < 130) begin
        q.delete();
        q.push_back(0);
        if (m_act_ok()) begin q.push_back(1); q.push_back(5); end
        if (m_rdwr_ok()) begin q.push_back(2); q.push_back(3); end
        if (m_pre_ok()) q.push_back(4);
        if ($urandom_range(0, 3) == 0)
          step(1'b1, 3'($urandom_range(0, 7)), 14'($urandom));
        else
          step(1'b1, 3'(q[$urandom_range(0, q.size() - 1)]), 14'($urandom));
      end else begin
        step(1'b0, 3'($urandom_range(0, 7)), 14'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
